// File: rtl/regfile_mp.sv
// Multi-read-port register file with byte-enabled writes, optional zero register,
// optional same-cycle write forwarding, and a self-clearing sequence after reset.

module regfile_mp_rdport #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [DATA_W-1:0]   i_word,
    input  logic                i_busy,
    input  logic                i_byp_en,
    input  logic [ADDR_W-1:0]   i_wr_addr,
    input  logic [DATA_W/8-1:0] i_wr_be,
    input  logic [DATA_W-1:0]   i_wr_data,
    output logic [DATA_W-1:0]   o_data
);
    localparam int NBYTE = DATA_W / 8;

    logic             w_hit;
    logic             w_zero;
    logic [DATA_W-1:0] w_merge;

    assign w_hit  = i_byp_en && (i_addr == i_wr_addr);
    assign w_zero = (ZERO_REG != 0) && (i_addr == '0);

    // Forwarded bytes overlay the stored word; disabled bytes pass through.
    always_comb begin
        w_merge = i_word;
        for (int b = 0; b < NBYTE; b++) begin
            if (w_hit && i_wr_be[b]) w_merge[b*8 +: 8] = i_wr_data[b*8 +: 8];
        end
    end

    assign o_data = (i_busy || w_zero) ? '0 : w_merge;
endmodule

module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en_i,
    input  logic [ADDR_W-1:0]       wr_addr_i,
    input  logic [DATA_W/8-1:0]     wr_be_i,
    input  logic [DATA_W-1:0]       wr_data_i,
    input  logic [NREAD*ADDR_W-1:0] rd_addr_i,
    output logic [NREAD*DATA_W-1:0] rd_data_o,
    output logic                    busy_o,
    output logic                    wr_drop_o
);
    localparam int NBYTE = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_IDLE  = 1'b1;

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic              r_wr_drop;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic w_busy;
    logic w_wr_zero;
    logic w_wr_commit;
    logic w_byp_en;

    assign w_busy      = (r_state == S_CLEAR);
    assign w_wr_zero   = (ZERO_REG != 0) && (wr_addr_i == '0);
    assign w_wr_commit = !w_busy && wr_en_i && !w_wr_zero;
    assign w_byp_en    = (BYPASS != 0) && !w_busy && wr_en_i;

    assign busy_o    = w_busy;
    assign wr_drop_o = r_wr_drop;

    // Clear walks every entry once; the counter wraps to 0 as it leaves CLEAR.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_CLEAR;
            r_clr_cnt <= '0;
            r_wr_drop <= 1'b0;
        end else begin
            r_wr_drop <= w_busy && wr_en_i;
            if (w_busy) begin
                if (r_clr_cnt == {ADDR_W{1'b1}}) r_state <= S_IDLE;
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end
        end
    end

    // Storage has no reset of its own; the clear sequence zeroes it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_busy) begin
                r_mem[r_clr_cnt] <= '0;
            end else if (w_wr_commit) begin
                for (int b = 0; b < NBYTE; b++) begin
                    if (wr_be_i[b]) r_mem[wr_addr_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
                end
            end
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_word;

        assign w_addr = rd_addr_i[k*ADDR_W +: ADDR_W];
        assign w_word = r_mem[w_addr];

        regfile_mp_rdport #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_rd (
            .i_addr    (w_addr),
            .i_word    (w_word),
            .i_busy    (w_busy),
            .i_byp_en  (w_byp_en),
            .i_wr_addr (wr_addr_i),
            .i_wr_be   (wr_be_i),
            .i_wr_data (wr_data_i),
            .o_data    (rd_data_o[k*DATA_W +: DATA_W])
        );
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: DUT A uses defaults (2 ports, bypass), DUT B has 4 ports
// and no bypass. Both share write inputs so one storage model serves both.

module tb_regfile_mp;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic [9:0]  rda;
    logic [63:0] rdd_a;
    logic        busy_a, drop_a;
    logic [19:0] rdb;
    logic [127:0] rdd_b;
    logic        busy_b, drop_b;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_mem [32];
    int          m_clear_left = 0;
    bit          m_drop = 0;

    regfile_mp u_dut_a (
        .clk(clk), .rst(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_be_i(wr_be),
        .wr_data_i(wr_data), .rd_addr_i(rda), .rd_data_o(rdd_a), .busy_o(busy_a),
        .wr_drop_o(drop_a)
    );

    regfile_mp #(.NREAD(4), .BYPASS(0)) u_dut_b (
        .clk(clk), .rst(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_be_i(wr_be),
        .wr_data_i(wr_data), .rd_addr_i(rdb), .rd_data_o(rdd_b), .busy_o(busy_b),
        .wr_drop_o(drop_b)
    );

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [3:0] be,
                                          input logic [31:0] d);
        logic [31:0] r = w;
        for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        logic [31:0] w;
        if (m_clear_left > 0 || a == 5'd0) return 32'h0;
        w = m_mem[a];
        if (byp && wr_en && wr_addr == a) w = merge(w, wr_be, wr_data);
        return w;
    endfunction

    // One clock: the model consumes the inputs present at the rising edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_clear_left = 32;
            m_drop = 0;
        end else if (m_clear_left > 0) begin
            m_mem[32 - m_clear_left] = 32'h0;
            m_drop = wr_en;
            m_clear_left--;
        end else begin
            m_drop = 0;
            if (wr_en && wr_addr != 5'd0) m_mem[wr_addr] = merge(m_mem[wr_addr], wr_be, wr_data);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        wr_en = 0; wr_addr = 0; wr_be = 0; wr_data = 0; rda = 10'h3FF; rdb = 20'hFFFFF;
        rst = 1'b1;
        tick();
        n_tests++;
        if (busy_a !== 1'b1 || busy_b !== 1'b1 || drop_a !== 1'b0 || drop_b !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: busy %b/%b drop %b/%b, want busy 1 drop 0",
                     busy_a, busy_b, drop_a, drop_b);
        end
        n_tests++;
        if (rdd_a !== 64'h0 || rdd_b !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_rd: got %h / %h, want all zero", rdd_a, rdd_b);
        end
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            n_tests++;
            if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
                n_fail++;
                $display("FAIL clear_busy cycle %0d: got %b/%b want 1", i, busy_a, busy_b);
            end
            tick();
        end
        n_tests++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_end: busy %b/%b after 32 cycles, want 0", busy_a, busy_b);
        end
    endtask

    task automatic test_clear_readback();
        for (int a = 0; a < 32; a++) begin
            rda = {2{a[4:0]}};
            rdb = {4{a[4:0]}};
            #1;
            n_tests++;
            if (rdd_a !== 64'h0 || rdd_b !== 128'h0) begin
                n_fail++;
                $display("FAIL clear_readback addr %0d: got %h / %h want 0", a, rdd_a, rdd_b);
            end
            tick();
        end
    endtask

    task automatic test_byte_merge();
        wr_en = 1; wr_addr = 5; wr_be = 4'hF; wr_data = 32'hDEADBEEF;
        tick();
        wr_be = 4'h1; wr_data = 32'h000000AA;
        tick();
        wr_en = 0;
        rda = {5'd0, 5'd5};
        rdb = {5'd0, 5'd0, 5'd0, 5'd5};
        #1;
        n_tests++;
        if (rdd_a[31:0] !== 32'hDEADBEAA || rdd_b[31:0] !== 32'hDEADBEAA) begin
            n_fail++;
            $display("FAIL byte_merge: got %h / %h want deadbeaa", rdd_a[31:0], rdd_b[31:0]);
        end
        tick();
    endtask

    task automatic test_bypass();
        wr_en = 1; wr_addr = 7; wr_be = 4'hF; wr_data = 32'hCAFEF00D;
        tick();
        wr_data = 32'h12345678;
        rda = {5'd7, 5'd0};
        rdb = {5'd0, 5'd0, 5'd7, 5'd0};
        #1;
        n_tests++;
        if (rdd_a[63:32] !== 32'h12345678) begin
            n_fail++;
            $display("FAIL bypass_fwd: got %h want 12345678", rdd_a[63:32]);
        end
        n_tests++;
        if (rdd_b[63:32] !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL nobypass_old: got %h want cafef00d", rdd_b[63:32]);
        end
        tick();
        wr_en = 0;
        #1;
        n_tests++;
        if (rdd_b[63:32] !== 32'h12345678 || rdd_a[63:32] !== 32'h12345678) begin
            n_fail++;
            $display("FAIL nobypass_next: got %h / %h want 12345678", rdd_a[63:32], rdd_b[63:32]);
        end
        wr_en = 1; wr_be = 4'b0110; wr_data = 32'hAABBCCDD;
        #1;
        n_tests++;
        if (rdd_a[63:32] !== 32'h12BBCC78 || rdd_b[63:32] !== 32'h12345678) begin
            n_fail++;
            $display("FAIL bypass_partial: got %h / %h want 12bbcc78 / 12345678",
                     rdd_a[63:32], rdd_b[63:32]);
        end
        tick();
        wr_be = 4'b0000; wr_data = 32'hFFFFFFFF;
        #1;
        n_tests++;
        if (rdd_a[63:32] !== 32'h12BBCC78) begin
            n_fail++;
            $display("FAIL bypass_be0: got %h want 12bbcc78", rdd_a[63:32]);
        end
        tick();
        wr_en = 0;
        #1;
        n_tests++;
        if (rdd_a[63:32] !== 32'h12BBCC78 || rdd_b[63:32] !== 32'h12BBCC78 || drop_a !== 1'b0) begin
            n_fail++;
            $display("FAIL be0_hold: got %h / %h drop %b want 12bbcc78 drop 0",
                     rdd_a[63:32], rdd_b[63:32], drop_a);
        end
        tick();
    endtask

    task automatic test_zero_reg();
        wr_en = 1; wr_addr = 0; wr_be = 4'hF; wr_data = 32'hFFFFFFFF;
        rda = 10'h0; rdb = 20'h0;
        #1;
        n_tests++;
        if (rdd_a !== 64'h0 || rdd_b !== 128'h0) begin
            n_fail++;
            $display("FAIL zero_same: got %h / %h want 0", rdd_a, rdd_b);
        end
        tick();
        wr_en = 0;
        #1;
        n_tests++;
        if (rdd_a !== 64'h0 || rdd_b !== 128'h0) begin
            n_fail++;
            $display("FAIL zero_next: got %h / %h want 0", rdd_a, rdd_b);
        end
        tick();
    endtask

    task automatic test_drop_in_clear();
        int cnt;
        do_reset();
        repeat (10) tick();
        wr_en = 1; wr_addr = 3; wr_be = 4'hF; wr_data = 32'hFFFFFFFF;
        tick();
        wr_en = 0;
        n_tests++;
        if (drop_a !== 1'b1 || drop_b !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_pulse: got %b/%b want 1", drop_a, drop_b);
        end
        tick();
        n_tests++;
        if (drop_a !== 1'b0 || drop_b !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_one_cycle: got %b/%b want 0", drop_a, drop_b);
        end
        cnt = 0;
        while (busy_a === 1'b1 && cnt < 40) begin
            cnt++;
            tick();
        end
        n_tests++;
        if (cnt != 20) begin
            n_fail++;
            $display("FAIL drop_clear_len: remaining busy %0d cycles want 20", cnt);
        end
        rda = {5'd3, 5'd3};
        rdb = {4{5'd3}};
        #1;
        n_tests++;
        if (rdd_a !== 64'h0 || rdd_b !== 128'h0) begin
            n_fail++;
            $display("FAIL drop_target: got %h / %h want 0", rdd_a, rdd_b);
        end
        tick();
    endtask

    task automatic test_rst_midclear();
        int cnt;
        wr_be = 4'hF;
        for (int a = 1; a < 32; a++) begin
            wr_en = 1; wr_addr = a[4:0]; wr_data = 32'h01010101 * a;
            tick();
        end
        wr_en = 0;
        do_reset();
        repeat (20) tick();
        rst = 1'b1;
        tick();
        n_tests++;
        if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
            n_fail++;
            $display("FAIL midclear_busy: got %b/%b want 1", busy_a, busy_b);
        end
        rst = 1'b0;
        cnt = 0;
        while (busy_a === 1'b1 && cnt < 40) begin
            cnt++;
            tick();
        end
        n_tests++;
        if (cnt != 32) begin
            n_fail++;
            $display("FAIL midclear_len: busy %0d cycles want 32", cnt);
        end
        for (int a = 0; a < 32; a += 4) begin
            rdb = {a[4:0] + 5'd3, a[4:0] + 5'd2, a[4:0] + 5'd1, a[4:0]};
            #1;
            n_tests++;
            if (rdd_b !== 128'h0) begin
                n_fail++;
                $display("FAIL midclear_zero base %0d: got %h want 0", a, rdd_b);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [4:0] b;
        for (int it = 0; it < 400; it++) begin
            wr_en   = ($urandom_range(0, 3) != 0);
            wr_addr = 5'($urandom_range(0, 31));
            wr_be   = 4'($urandom_range(0, 15));
            wr_data = $urandom;
            rda     = 10'($urandom);
            if (it % 2 == 0) begin
                b   = 5'($urandom_range(0, 31));
                rdb = {b + 5'd22, b + 5'd13, b + 5'd7, b};
            end else begin
                rdb = 20'($urandom);
            end
            #1;
            for (int p = 0; p < 2; p++) begin
                n_tests++;
                if (rdd_a[p*32 +: 32] !== exp_rd(rda[p*5 +: 5], 1'b1)) begin
                    n_fail++;
                    $display("FAIL rand_a it %0d port %0d addr %0d: got %h want %h", it, p,
                             rda[p*5 +: 5], rdd_a[p*32 +: 32], exp_rd(rda[p*5 +: 5], 1'b1));
                end
            end
            for (int p = 0; p < 4; p++) begin
                n_tests++;
                if (rdd_b[p*32 +: 32] !== exp_rd(rdb[p*5 +: 5], 1'b0)) begin
                    n_fail++;
                    $display("FAIL rand_b it %0d port %0d addr %0d: got %h want %h", it, p,
                             rdb[p*5 +: 5], rdd_b[p*32 +: 32], exp_rd(rdb[p*5 +: 5], 1'b0));
                end
            end
            tick();
            n_tests++;
            if (drop_a !== m_drop || drop_b !== m_drop) begin
                n_fail++;
                $display("FAIL rand_drop it %0d: got %b/%b want %b", it, drop_a, drop_b, m_drop);
            end
        end
        wr_en = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
        rst = 1'b1;
        test_reset();
        test_clear_readback();
        test_byte_merge();
        test_bypass();
        test_zero_reg();
        test_drop_in_clear();
        test_rst_midclear();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
